// File: rtl/scarv_cop_aes_subword_ctrl_pkg.sv
// Shared AES coprocessor definitions: sub-word FSM encoding,
// word geometry and GF(2^8) helpers used by the SBox.
package scarv_cop_aes_subword_ctrl_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } sw_state_e;

  function automatic logic [7:0] rol8(
    input logic [7:0] x,
    input int         n
  );
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse, and maps 0 to 0.
  function automatic logic [7:0] gf_inv(
    input logic [7:0] a
  );
    logic [7:0] r;
    logic [7:0] b;
    r = 8'h01;
    b = a;
    for (int i = 1; i < 8; i++) begin
      b = gf_mul(b, b);
      r = gf_mul(r, b);
    end
    return r;
  endfunction

  function automatic logic [7:0] aff_fwd(
    input logic [7:0] b
  );
    return b ^ rol8(b, 1) ^ rol8(b, 2)
             ^ rol8(b, 3) ^ rol8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] aff_inv(
    input logic [7:0] s
  );
    return rol8(s, 1) ^ rol8(s, 3)
         ^ rol8(s, 6) ^ 8'h05;
  endfunction

endpackage

// File: rtl/scarv_cop_aes_sbox.sv
// Combined forward/inverse AES SBox, one byte, purely combinational.
// Both directions share a single GF(2^8) inverter.
module scarv_cop_aes_sbox
  import scarv_cop_aes_subword_ctrl_pkg::*;
(
  input  logic [7:0] i_byte,
  input  logic       i_inv,
  output logic [7:0] o_byte
);

  logic [7:0] w_pre;
  logic [7:0] w_gfi;

  assign w_pre  = i_inv ? aff_inv(i_byte) : i_byte;
  assign w_gfi  = gf_inv(w_pre);
  assign o_byte = i_inv ? w_gfi : aff_fwd(w_gfi);

endmodule

// File: rtl/scarv_cop_aes_subword_ctrl.sv
// Sequential SubWord unit: substitutes a 32-bit word LANES bytes
// per cycle through shared SBox lanes, with valid/ready handshakes.
module scarv_cop_aes_subword_ctrl
  import scarv_cop_aes_subword_ctrl_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_word,
  input  logic        req_inv,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_word,
  input  logic        flush
);

  localparam logic [1:0] STEP = 2'(LANES);
  localparam logic [1:0] LAST = 2'(WORD_BYTES - LANES);

  if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
    $error("LANES must be 1, 2 or 4");
  end

  sw_state_e   r_state;
  sw_state_e   w_state_nxt;
  logic [1:0]  r_cnt;
  logic [31:0] r_word;
  logic        r_inv;
  logic [31:0] r_res;
  logic [31:0] w_res_nxt;
  logic        w_accept;
  logic        w_busy;
  logic [7:0]  w_lane_in  [LANES];
  logic [7:0]  w_lane_out [LANES];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign w_lane_in[l] = r_word[8*(int'(r_cnt)+l) +: 8];
    scarv_cop_aes_sbox u_sbox (
      .i_byte (w_lane_in[l]),
      .i_inv  (r_inv),
      .o_byte (w_lane_out[l])
    );
  end

  always_comb begin
    w_res_nxt = r_res;
    for (int l = 0; l < LANES; l++) begin
      w_res_nxt[8*(int'(r_cnt)+l) +: 8] = w_lane_out[l];
    end
  end

  assign w_busy    = (r_state == ST_BUSY);
  assign w_accept  = req_valid && (r_state == ST_IDLE) && !flush;
  assign req_ready = (r_state == ST_IDLE);
  assign rsp_valid = (r_state == ST_DONE);
  assign rsp_word  = r_res;

  // Flush beats both handshakes on the same edge.
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: if (req_valid)     w_state_nxt = ST_BUSY;
        ST_BUSY: if (r_cnt == LAST) w_state_nxt = ST_DONE;
        ST_DONE: if (rsp_ready)     w_state_nxt = ST_IDLE;
        default:                    w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_state <= ST_IDLE;
      r_cnt   <= 2'd0;
      r_word  <= 32'd0;
      r_inv   <= 1'b0;
      r_res   <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      if (flush) begin
        r_cnt <= 2'd0;
      end else if (w_accept) begin
        r_word <= req_word;
        r_inv  <= req_inv;
        r_cnt  <= 2'd0;
      end else if (w_busy) begin
        r_res <= w_res_nxt;
        r_cnt <= r_cnt + STEP;
      end
    end
  end

endmodule

// File: doc/scarv_cop_aes_subword_ctrl.md
SCARV_COP_AES_SUBWORD_CTRL -- requirements
Module: scarv_cop_aes_subword_ctrl

Interface
REQ-001 SHALL have parameter LANES, default 1, meaning the number of scarv_cop_aes_sbox instances; legal values are 1, 2 and 4.
REQ-002 SHALL have port g_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port g_resetn, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port req_valid, input, 1 bit: request present.
REQ-005 SHALL have port req_ready, output, 1 bit: block can accept a request.
REQ-006 SHALL have port req_word, input, 32 bits: word to substitute; byte k is bits [8k+7:8k].
REQ-007 SHALL have port req_inv, input, 1 bit: 1 selects the inverse SBox, 0 the forward SBox.
REQ-008 SHALL have port rsp_valid, output, 1 bit: result available.
REQ-009 SHALL have port rsp_ready, input, 1 bit: consumer accepts the result.
REQ-010 SHALL have port rsp_word, output, 32 bits: substituted word.
REQ-011 SHALL have port flush, input, 1 bit: synchronous abort.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-013 SHALL drive req_ready=1 only in IDLE and rsp_valid=1 only in DONE.
REQ-014 SHALL accept a request on an edge with req_valid && req_ready, capturing req_word and req_inv into internal registers, clearing the byte counter and entering BUSY.
REQ-015 SHALL ignore req_word and req_inv changes after acceptance.
REQ-016 SHALL, in each BUSY cycle, feed bytes [cnt .. cnt+LANES-1] to the sbox lanes with inv=captured req_inv, write the lane outputs into the same byte positions of the result register, and advance cnt by LANES.
REQ-017 SHALL process bytes in ascending order, byte 0 first.
REQ-018 SHALL use a byte counter 2 bits wide that wraps to 0 after the final group; the FSM moves BUSY->DONE when the final group (cnt = 4-LANES) is written.
REQ-019 SHALL keep BUSY for exactly 4/LANES cycles, so rsp_valid rises 4/LANES cycles after the accepting edge.
REQ-020 SHALL hold rsp_word and rsp_valid stable in DONE until rsp_ready=1; on that edge it SHALL move DONE->IDLE.
REQ-021 SHALL hold rsp_word at the last result after leaving DONE, until the next result overwrites it.
REQ-022 SHALL not accept a new request on the same edge as the response handshake; the earliest acceptance is the following cycle.
REQ-023 SHALL, on flush=1, enter IDLE on the next edge from any state, discarding work in progress and any pending result.
REQ-024 SHALL give flush priority over every other event on the same edge, including the request and response handshakes.
REQ-025 SHALL treat a flush asserted while in IDLE as a no-op, and SHALL not accept a request presented on that edge.
REQ-026 SHALL keep state unchanged when req_valid=0 in IDLE, or when rsp_ready=0 in DONE.

Reset
REQ-027 SHALL, while g_resetn=0, asynchronously force the state to IDLE, cnt=0, the captured word, inv and result registers to 0, and outputs req_ready=1, rsp_valid=0 and rsp_word=0.
REQ-028 SHALL, on reset asserted mid-operation, abandon the operation without producing a response; the first request after deassertion behaves as a request from power-up.

Structure
REQ-029 SHALL reuse the existing scarv_cop_aes_sbox as its only sub-module, instantiated LANES times via generate.
REQ-030 SHALL place the FSM state encoding and the localparam WORD_BYTES=4 in the shared coprocessor package.
REQ-031 SHALL reject LANES values other than 1, 2 or 4 at elaboration.

Verification
REQ-032 SHALL cover a forward request: LANES=1, req_word=0x53020100, req_inv=0 -> rsp_valid rises 4 cycles after acceptance with rsp_word=0xED777C63.
REQ-033 SHALL cover an inverse request: LANES=4, req_word=0xED777C63, req_inv=1 -> rsp_valid rises 1 cycle after acceptance with rsp_word=0x53020100.
REQ-034 SHALL cover backpressure: LANES=2, req_word=0xFFFFFFFF, rsp_ready held 0 for 5 cycles -> rsp_word stays 0x16161616, rsp_valid stays 1 and req_ready stays 0 until rsp_ready=1.
REQ-035 SHALL cover flush mid-operation: LANES=1, flush asserted 2 cycles after acceptance -> IDLE next cycle, rsp_valid never asserted, and a following request 0x00000000 returns 0x63636363.
REQ-036 SHALL cover flush colliding with a request: flush=1 and req_valid=1 on the same edge in IDLE -> the request is not accepted and the state stays IDLE.
REQ-037 SHALL cover reset in BUSY: g_resetn pulsed low -> immediate req_ready=1, rsp_valid=0, rsp_word=0, after which a fresh request completes correctly.
